alu_issue: RTL and testbench
============================

// Module: alu_issue
// PURPOSE
//  Execute-stage sequencer that sits directly upstream of the 16-bit ALU. Accepts decoded two-operand
//  ops, drives the ALU's single operand port (B-latch load, then execute), captures result and nzcv,
//  presents them to writeback over a valid/ready handshake, and owns the architectural flag register.
// PARAMETERS
//  W      16  datapath width (ALU fixed at 16; other values unsupported)
//  RDW    3   destination register index width
// PORTS
//  clk        in   1    clock; state updates on rising edge
//  rst_n      in   1    asynchronous reset, active low
//  in_valid   in   1    decoded op available
//  in_ready   out  1    op accepted when in_valid && in_ready at rising edge
//  in_op      in   4    ALU opcode
//  in_a       in   W    operand A
//  in_b       in   W    operand B
//  in_rd      in   RDW  destination register
//  in_setf    in   1    update flag register from this op
//  alu_a      out  W    to ALU a
//  alu_op     out  4    to ALU op
//  alu_r      in   W    from ALU r (valid at rising edge after the cycle it was driven)
//  alu_f      in   4    from ALU f: [3]=n [2]=z [1]=c [0]=v
//  wb_valid   out  1    result pending
//  wb_ready   in   1    writeback accepts result
//  wb_data    out  W    result
//  wb_rd      out  RDW  destination register
//  flags      out  4    architectural nzcv
// BEHAVIOUR
//  - ALU evaluates on the falling edge, so alu_a/alu_op are driven from registers updated on rising edge
//    and are stable half a cycle before use; alu_r/alu_f are sampled on the next rising edge.
//  - States: IDLE, LDB, EXEC, WB.
//    IDLE: in_ready=1, alu_op=0000. Accept -> capture op/a/b/rd/setf -> LDB.
//    LDB : alu_op=1100, alu_a=b_q (loads ALU B latch) -> EXEC.
//    EXEC: alu_op=op_q, alu_a=a_q -> WB; at that edge wb_data<=alu_r, wb_rd<=rd_q, flags updated.
//    WB  : wb_valid=1; wb_data/wb_rd held stable until wb_ready. If wb_ready: in_ready=1; accept -> LDB,
//          else -> IDLE.
//  - Latency: accept edge to wb_valid = 2 cycles (3rd rising edge); back-to-back throughput 1 op/3 cycles.
//  - in_op=1100 is reserved: accepted, executed as 0000 (pass a); 1100 is only issued in LDB.
//  - Flag update (only when setf_q): n,z,v <= alu_f[3],alu_f[2],alu_f[0]; c <= alu_f[1] only for
//    op 0001/0010/1000, else c retained (ALU carry is stale for other ops).
//  - Shift ops use b[3:0] only; block forwards full b unchanged.
//  - Reset (any state, incl. mid-LDB/EXEC/WB): state=IDLE, wb_valid=0, wb_data=0, wb_rd=0, flags=0000,
//    alu_op=0000, alu_a=0, in-flight op discarded; ALU B latch treated as unknown.
// CONFIGURATION
//  ALU_BCACHE_EN defined: register last B loaded into ALU plus valid bit (cleared by reset). On accept,
//    if valid && in_b==cached B, skip LDB (IDLE/WB -> EXEC); latency 1 cycle, throughput 1 op/2 cycles.
//  Undefined: LDB always executed; no cache registers.
// STRUCTURE
//  - Package pine16_alu_pkg: opcode constants (OP_PASS 0000, OP_ADD 0001, OP_SUB 0010, OP_AND 0100,
//    OP_OR 0101, OP_XOR 0110, OP_SHR 0111, OP_SHL 1000, OP_LDB 1100), flag bit indices, state encoding.
//  - One sub-module: alu_flag_reg (flag register with setf and carry-retain logic).
// TESTING
//  1. rst_n low during EXEC -> same cycle wb_valid=0, flags=0000, in_ready=1; no wb for dropped op.
//  2. ADD a=FFFF b=0001 setf=1 -> alu_op 1100 then 0001; wb_data=0000, flags z=1 c=1 at 3rd edge.
//  3. Then AND a=00F0 b=0F00 setf=1 -> wb_data=0000, flags z=1, c stays 1.
//  4. wb_ready low 5 cycles in WB -> wb_data/wb_rd stable, in_ready=0; release -> next op accepted.
//  5. in_op=1100 a=1234 -> EXEC drives alu_op=0000, wb_data=1234.
//  6. ALU_BCACHE_EN: two SUB with b=0003 back-to-back -> 2nd skips LDB, wb_valid 1 cycle after accept;
//     macro off -> 2 cycles.

Source files
------------

// File: rtl/pine16_alu_pkg.sv
// Shared definitions for the pine16 ALU issue stage: opcodes, nzcv bit positions and sequencer states.
package pine16_alu_pkg;

    localparam int ALU_W = 16;

    localparam logic [3:0] OP_PASS = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_SUB  = 4'b0010;
    localparam logic [3:0] OP_AND  = 4'b0100;
    localparam logic [3:0] OP_OR   = 4'b0101;
    localparam logic [3:0] OP_XOR  = 4'b0110;
    localparam logic [3:0] OP_SHR  = 4'b0111;
    localparam logic [3:0] OP_SHL  = 4'b1000;
    localparam logic [3:0] OP_LDB  = 4'b1100;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LDB  = 2'd1,
        ST_EXEC = 2'd2,
        ST_WB   = 2'd3
    } state_e;

    // LDB is owned by the sequencer; a decoded LDB request degrades to pass-a.
    function automatic logic [3:0] op_remap(input logic [3:0] op);
        return (op == OP_LDB) ? OP_PASS : op;
    endfunction

    // Only these ops produce a meaningful ALU carry.
    function automatic logic carry_valid(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_SHL);
    endfunction

endpackage

// File: rtl/alu_flag_reg.sv
// Architectural nzcv register: loads on update, keeping the previous carry for ops whose ALU carry is stale.
module alu_flag_reg
    import pine16_alu_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       upd_i,
    input  logic [3:0] op_i,
    input  logic [3:0] f_i,
    output logic [3:0] flags_o
);

    logic [3:0] flags_q;
    logic [3:0] flags_d;

    always_comb begin
        flags_d = f_i;
        if (!carry_valid(op_i)) begin
            flags_d[FLAG_C] = flags_q[FLAG_C];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q <= '0;
        end else if (upd_i) begin
            flags_q <= flags_d;
        end
    end

    assign flags_o = flags_q;

endmodule

// File: rtl/alu_issue.sv
// Execute-stage sequencer for the 16-bit ALU (B-latch load, execute, writeback handshake).
// Optional ALU_BCACHE_EN: remembers the last B loaded so a repeated B skips the LDB cycle.
module alu_issue
    import pine16_alu_pkg::*;
#(
    parameter int W   = 16,
    parameter int RDW = 3
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [3:0]     in_op,
    input  logic [W-1:0]   in_a,
    input  logic [W-1:0]   in_b,
    input  logic [RDW-1:0] in_rd,
    input  logic           in_setf,
    output logic [W-1:0]   alu_a,
    output logic [3:0]     alu_op,
    input  logic [W-1:0]   alu_r,
    input  logic [3:0]     alu_f,
    output logic           wb_valid,
    input  logic           wb_ready,
    output logic [W-1:0]   wb_data,
    output logic [RDW-1:0] wb_rd,
    output logic [3:0]     flags
);

    state_e         state_q;
    logic           wb_valid_q;
    logic [W-1:0]   wb_data_q;
    logic [RDW-1:0] wb_rd_q;
    logic [3:0]     alu_op_q;
    logic [W-1:0]   alu_a_q;

    logic [3:0]     op_q;
    logic [W-1:0]   a_q;
    logic [RDW-1:0] rd_q;
    logic           setf_q;

    logic accept;
    logic hit;

    assign in_ready = (state_q == ST_IDLE) || ((state_q == ST_WB) && wb_ready);
    assign accept   = in_valid && in_ready;

`ifdef ALU_BCACHE_EN
    logic [W-1:0] bc_q;
    logic         bc_vld_q;

    // Reset leaves the ALU B latch unknown, so the cache starts invalid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bc_vld_q <= 1'b0;
            bc_q     <= '0;
        end else if (accept && !hit) begin
            bc_vld_q <= 1'b1;
            bc_q     <= in_b;
        end
    end

    assign hit = bc_vld_q && (bc_q == in_b);
`else
    assign hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (accept) begin
            op_q   <= op_remap(in_op);
            a_q    <= in_a;
            rd_q   <= in_rd;
            setf_q <= in_setf;
        end
    end

    // alu_op/alu_a are registered so they settle half a cycle before the ALU's falling-edge evaluation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            wb_valid_q <= 1'b0;
            wb_data_q  <= '0;
            wb_rd_q    <= '0;
            alu_op_q   <= OP_PASS;
            alu_a_q    <= '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_WB: begin
                    if (in_ready) begin
                        state_q    <= ST_IDLE;
                        wb_valid_q <= 1'b0;
                        alu_op_q   <= OP_PASS;
                    end
                    if (accept) begin
                        if (hit) begin
                            state_q  <= ST_EXEC;
                            alu_op_q <= op_remap(in_op);
                            alu_a_q  <= in_a;
                        end else begin
                            state_q  <= ST_LDB;
                            alu_op_q <= OP_LDB;
                            alu_a_q  <= in_b;
                        end
                    end
                end
                ST_LDB: begin
                    state_q  <= ST_EXEC;
                    alu_op_q <= op_q;
                    alu_a_q  <= a_q;
                end
                ST_EXEC: begin
                    state_q    <= ST_WB;
                    wb_valid_q <= 1'b1;
                    wb_data_q  <= alu_r;
                    wb_rd_q    <= rd_q;
                    alu_op_q   <= OP_PASS;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    alu_flag_reg u_flags (
        .clk     (clk),
        .rst_n   (rst_n),
        .upd_i   ((state_q == ST_EXEC) && setf_q),
        .op_i    (op_q),
        .f_i     (alu_f),
        .flags_o (flags)
    );

    assign alu_op   = alu_op_q;
    assign alu_a    = alu_a_q;
    assign wb_valid = wb_valid_q;
    assign wb_data  = wb_data_q;
    assign wb_rd    = wb_rd_q;

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue with a falling-edge ALU model; honours ALU_BCACHE_EN for latency expectations.
module tb_alu_issue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_op;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic [2:0]  in_rd;
    logic        in_setf;
    logic [15:0] alu_a;
    logic [3:0]  alu_op;
    logic [15:0] alu_r;
    logic [3:0]  alu_f;
    logic        wb_valid;
    logic        wb_ready;
    logic [15:0] wb_data;
    logic [2:0]  wb_rd;
    logic [3:0]  flags;

    int n_chk = 0;
    int n_fail = 0;

    alu_issue #(.W(16), .RDW(3)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_op    (in_op),
        .in_a     (in_a),
        .in_b     (in_b),
        .in_rd    (in_rd),
        .in_setf  (in_setf),
        .alu_a    (alu_a),
        .alu_op   (alu_op),
        .alu_r    (alu_r),
        .alu_f    (alu_f),
        .wb_valid (wb_valid),
        .wb_ready (wb_ready),
        .wb_data  (wb_data),
        .wb_rd    (wb_rd),
        .flags    (flags)
    );

    always #5 clk = ~clk;

    // ALU model: B latch loads on op 1100, otherwise evaluates a op B on the falling edge.
    logic [15:0] blat = 16'h0;
    logic [16:0] t17;
    logic [15:0] ov;
    logic        mc;
    logic        mv;
    int          sh;

    always @(negedge clk) begin
        if (alu_op == 4'b1100) begin
            blat = alu_a;
        end else begin
            mc = 1'b0;
            mv = 1'b0;
            sh = int'(blat[3:0]);
            case (alu_op)
                4'b0001: begin
                    t17 = {1'b0, alu_a} + {1'b0, blat};
                    alu_r = t17[15:0];
                    mc = t17[16];
                    ov = ~(alu_a ^ blat) & (alu_a ^ alu_r);
                    mv = ov[15];
                end
                4'b0010: begin
                    alu_r = alu_a - blat;
                    mc = (alu_a >= blat);
                    ov = (alu_a ^ blat) & (alu_a ^ alu_r);
                    mv = ov[15];
                end
                4'b0100: alu_r = alu_a & blat;
                4'b0101: alu_r = alu_a | blat;
                4'b0110: alu_r = alu_a ^ blat;
                4'b0111: begin
                    alu_r = alu_a >> sh;
                    if (sh != 0) mc = alu_a[sh-1];
                end
                4'b1000: begin
                    alu_r = alu_a << sh;
                    if (sh != 0) mc = alu_a[16-sh];
                end
                default: alu_r = alu_a;
            endcase
            alu_f = {alu_r[15], (alu_r == 16'h0), mc, mv};
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Bench-side view of which B the ALU latch holds, used only to predict the cached-B skip.
    logic        m_bvld = 1'b0;
    logic [15:0] m_blast = 16'h0;

    task automatic do_op(input string tag, input logic [3:0] op, input logic [15:0] a,
                         input logic [15:0] b, input logic [2:0] rd, input logic setf,
                         input logic [15:0] exp_d, input logic [3:0] exp_f, input int hold);
        logic       skip;
        logic [3:0] eop;
        eop = (op == 4'b1100) ? 4'b0000 : op;
`ifdef ALU_BCACHE_EN
        skip = m_bvld && (m_blast == b);
`else
        skip = 1'b0;
`endif
        wb_ready = 1'b1;
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        in_rd    = rd;
        in_setf  = setf;
        #1;
        chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wb_ready = (hold > 0) ? 1'b0 : 1'b1;
        if (!skip) begin
            chk({tag, ".ldb_op"}, 32'(alu_op), 32'hC);
            chk({tag, ".ldb_a"}, 32'(alu_a), 32'(b));
            chk({tag, ".ldb_wbv"}, 32'(wb_valid), 32'd0);
            m_bvld  = 1'b1;
            m_blast = b;
            @(posedge clk);
            #1;
        end
        chk({tag, ".exec_op"}, 32'(alu_op), 32'(eop));
        chk({tag, ".exec_a"}, 32'(alu_a), 32'(a));
        chk({tag, ".exec_wbv"}, 32'(wb_valid), 32'd0);
        @(posedge clk);
        #1;
        chk({tag, ".wb_valid"}, 32'(wb_valid), 32'd1);
        chk({tag, ".wb_data"}, 32'(wb_data), 32'(exp_d));
        chk({tag, ".wb_rd"}, 32'(wb_rd), 32'(rd));
        chk({tag, ".flags"}, 32'(flags), 32'(exp_f));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            chk({tag, ".hold_wbv"}, 32'(wb_valid), 32'd1);
            chk({tag, ".hold_data"}, 32'(wb_data), 32'(exp_d));
            chk({tag, ".hold_rd"}, 32'(wb_rd), 32'(rd));
            chk({tag, ".hold_rdy"}, 32'(in_ready), 32'd0);
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_op    = 4'h0;
        in_a     = 16'h0;
        in_b     = 16'h0;
        in_rd    = 3'h0;
        in_setf  = 1'b0;
        wb_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.wb_valid", 32'(wb_valid), 32'd0);
        chk("rst.wb_data", 32'(wb_data), 32'd0);
        chk("rst.wb_rd", 32'(wb_rd), 32'd0);
        chk("rst.flags", 32'(flags), 32'd0);
        chk("rst.in_ready", 32'(in_ready), 32'd1);
        chk("rst.alu_op", 32'(alu_op), 32'd0);
        chk("rst.alu_a", 32'(alu_a), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // ADD carry-out to zero, then AND keeps the old carry, then reserved op passes a.
        do_op("add", 4'b0001, 16'hFFFF, 16'h0001, 3'd1, 1'b1, 16'h0000, 4'b0110, 0);
        do_op("and", 4'b0100, 16'h00F0, 16'h0F00, 3'd2, 1'b1, 16'h0000, 4'b0110, 0);
        do_op("rsv", 4'b1100, 16'h1234, 16'h0005, 3'd3, 1'b1, 16'h1234, 4'b0010, 0);
        do_op("xor", 4'b0110, 16'hFF00, 16'h0F0F, 3'd5, 1'b0, 16'hF00F, 4'b0010, 5);
        do_op("shl", 4'b1000, 16'h0001, 16'h0013, 3'd6, 1'b1, 16'h0008, 4'b0000, 0);
        do_op("sub1", 4'b0010, 16'h0005, 16'h0003, 3'd4, 1'b1, 16'h0002, 4'b0010, 0);
        do_op("sub2", 4'b0010, 16'h0003, 16'h0003, 3'd4, 1'b1, 16'h0000, 4'b0110, 0);

        // Reset while an op sits in EXEC: the op must vanish.
        wb_ready = 1'b1;
        in_valid = 1'b1;
        in_op    = 4'b0001;
        in_a     = 16'h0001;
        in_b     = 16'h0777;
        in_rd    = 3'd7;
        in_setf  = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("drop.exec_op", 32'(alu_op), 32'h1);
        rst_n  = 1'b0;
        m_bvld = 1'b0;
        #1;
        chk("drop.wb_valid", 32'(wb_valid), 32'd0);
        chk("drop.flags", 32'(flags), 32'd0);
        chk("drop.in_ready", 32'(in_ready), 32'd1);
        chk("drop.alu_op", 32'(alu_op), 32'd0);
        chk("drop.wb_data", 32'(wb_data), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("drop.no_wb", 32'(wb_valid), 32'd0);
        end

        do_op("or", 4'b0101, 16'h00F0, 16'h0F0F, 3'd2, 1'b1, 16'h0FFF, 4'b0000, 0);
        @(posedge clk);
        #1;
        chk("end.idle_rdy", 32'(in_ready), 32'd1);
        chk("end.wb_valid", 32'(wb_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
